// File: rtl/tape_pkg.sv
// Shared types for the tape byte injector.
// State encoding, buffered write entry and depth default.
package tape_pkg;

  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_EXEC
  } state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } entry_t;

  // True on the transition out of IDLE.
  function automatic logic leaves_idle(
    input state_t cur,
    input state_t nxt
  );
    return (cur == ST_IDLE) && (nxt != ST_IDLE);
  endfunction

endpackage

// File: rtl/tape_inject_fifo.sv
// Small write-entry FIFO for the tape injector.
// Pointers carry one extra wrap bit to tell full from empty.
module tape_inject_fifo
  import tape_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer advance; reset drops every pending entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Entry storage, no reset needed behind the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/tape_inject.sv
// Tape loader RAM injector: buffers parsed bytes, writes them, then jumps.
// Optional running checksum of written bytes: TAPE_INJECT_CHECKSUM_EN.
module tape_inject
  import tape_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [15:0] in_addr,
  input  logic [7:0]  in_data,
  input  logic        in_done,
  output logic        in_ready,
  output logic        ram_req,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_dout,
  input  logic        ram_ack,
  output logic        cpu_hold,
  output logic        exec_req,
  output logic [15:0] exec_addr,
  input  logic        exec_ack,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  checksum
);

  state_t      state_q;
  state_t      state_d;
  logic        fifo_full;
  logic        fifo_empty;
  entry_t      head;
  entry_t      push_entry;
  logic        push;
  logic        pop;
  logic        ovf_set;
  logic        latch_exec;
  logic        leave_idle;
  logic        can_load;
  logic [15:0] exec_addr_q;
  logic        ovf_q;

  assign push_entry = '{addr: in_addr, data: in_data};
  assign can_load   = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign ram_req    = ~fifo_empty;
  assign pop        = ram_req & ram_ack;
  assign leave_idle = leaves_idle(state_q, state_d);

  tape_inject_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state, push/drop decision and exec address capture.
  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    ovf_set    = 1'b0;
    latch_exec = 1'b0;
    if (in_valid) begin
      if (can_load && !fifo_full) push = 1'b1;
      else                        ovf_set = 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (in_done) begin
          latch_exec = 1'b1;
          state_d    = ST_DRAIN;
        end else if (in_valid) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_done) begin
          latch_exec = 1'b1;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Jump target, taken from in_addr on the done pulse.
  always_ff @(posedge clk) begin
    if (!reset_n)        exec_addr_q <= 16'h0000;
    else if (latch_exec) exec_addr_q <= in_addr;
  end

  // Sticky drop flag, cleared when a new load begins.
  always_ff @(posedge clk) begin
    if (!reset_n)        ovf_q <= 1'b0;
    else if (leave_idle) ovf_q <= 1'b0;
    else if (ovf_set)    ovf_q <= 1'b1;
  end

`ifdef TAPE_INJECT_CHECKSUM_EN
  logic [7:0] sum_q;

  // Running sum of bytes accepted by the RAM since the load began.
  always_ff @(posedge clk) begin
    if (!reset_n)        sum_q <= 8'h00;
    else if (leave_idle) sum_q <= 8'h00;
    else if (pop)        sum_q <= sum_q + head.data;
  end

  assign checksum = sum_q;
`else
  assign checksum = 8'h00;
`endif

  assign in_ready  = ~fifo_full;
  assign ram_addr  = head.addr;
  assign ram_dout  = head.data;
  assign busy      = (state_q != ST_IDLE);
  assign cpu_hold  = busy;
  assign exec_req  = (state_q == ST_EXEC);
  assign exec_addr = exec_addr_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_tape_inject.sv
// Bench for tape_inject: queue-level reference model plus directed cases.
// Outputs compared every falling edge; inputs driven on falling edges.
module tb_tape_inject;
  import tape_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] in_addr;
  logic [7:0]  in_data;
  logic        in_done;
  logic        in_ready;
  logic        ram_req;
  logic [15:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_ack;
  logic        cpu_hold;
  logic        exec_req;
  logic [15:0] exec_addr;
  logic        exec_ack;
  logic        busy;
  logic        overflow;
  logic [7:0]  checksum;

  int checks = 0;
  int failures = 0;

  tape_inject #(.FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .in_done  (in_done),
    .in_ready (in_ready),
    .ram_req  (ram_req),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .ram_ack  (ram_ack),
    .cpu_hold (cpu_hold),
    .exec_req (exec_req),
    .exec_addr(exec_addr),
    .exec_ack (exec_ack),
    .busy     (busy),
    .overflow (overflow),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 load, 2 drain, 3 exec.
  int          m_ph;
  entry_t      q[$];
  entry_t      m_log[$];
  entry_t      d_log[$];
  logic [15:0] m_xa;
  logic        m_ovf;
  logic [7:0]  m_sum;
  bit          m_ok = 0;
  logic        snap_req;
  entry_t      snap_ent;

  initial begin
    int n;
    int nph;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        m_ph = 0;
        q.delete();
        m_log.delete();
        d_log.delete();
        m_xa = 16'h0000;
        m_ovf = 1'b0;
        m_sum = 8'h00;
        m_ok = 1;
      end else begin
        if (snap_req === 1'b1 && ram_ack) d_log.push_back(snap_ent);
        n = q.size();
        nph = m_ph;
        if (m_ph == 0 && (in_valid || in_done)) begin
          m_ovf = 1'b0;
          m_sum = 8'h00;
        end
        if (n > 0 && ram_ack) begin
          m_sum = m_sum + q[0].data;
          m_log.push_back(q[0]);
          q.pop_front();
        end
        if (in_valid) begin
          if (m_ph <= 1 && n < DEPTH) q.push_back(entry_t'({in_addr, in_data}));
          else m_ovf = 1'b1;
        end
        case (m_ph)
          0: if (in_done) begin m_xa = in_addr; nph = 2; end
             else if (in_valid) nph = 1;
          1: if (in_done) begin m_xa = in_addr; nph = 2; end
          2: if (n == 0) nph = 3;
          default: if (exec_ack) nph = 0;
        endcase
        m_ph = nph;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    logic [7:0] exp_ck;
    forever begin
      @(negedge clk);
      snap_req = ram_req;
      snap_ent = entry_t'({ram_addr, ram_dout});
      if (m_ok) begin
`ifdef TAPE_INJECT_CHECKSUM_EN
        exp_ck = m_sum;
`else
        exp_ck = 8'h00;
`endif
        chk("in_ready", in_ready, q.size() < DEPTH);
        chk("ram_req", ram_req, q.size() != 0);
        if (q.size() != 0) begin
          chk("ram_addr", ram_addr, q[0].addr);
          chk("ram_dout", ram_dout, q[0].data);
        end
        chk("busy", busy, m_ph != 0);
        chk("cpu_hold", cpu_hold, m_ph != 0);
        chk("exec_req", exec_req, m_ph == 3);
        chk("exec_addr", exec_addr, m_xa);
        chk("overflow", overflow, m_ovf);
        chk("checksum", checksum, exp_ck);
      end
    end
  end

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_done  = 1'b0;
    in_addr  = 16'h0000;
    in_data  = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_inputs();
    ram_ack = 1'b0;
    exec_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Bounded wait for exec_req, then a one-cycle exec_ack.
  task automatic finish_exec(input string nm);
    bit ok;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      if (exec_req === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
      idle_inputs();
    end
    chk({nm, "_exec_seen"}, ok, 1);
    exec_ack = 1'b1;
    @(negedge clk);
    exec_ack = 1'b0;
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_idle_hold"}, cpu_hold, 0);
  endtask

  task automatic send(input logic [15:0] a, input logic [7:0] d,
                      input logic dn);
    @(negedge clk);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_done  = dn;
  endtask

  task automatic send_done(input logic [15:0] a);
    @(negedge clk);
    in_valid = 1'b0;
    in_addr  = a;
    in_done  = 1'b1;
  endtask

  initial begin
    bit saw_req;
    bit found;
    reset_n = 1'b0;
    idle_inputs();
    ram_ack = 1'b0;
    exec_ack = 1'b0;
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_exec_addr", exec_addr, 16'h0000);

    // Two bytes then done, RAM accepting every cycle.
    ram_ack = 1'b1;
    send(16'h694D, 8'h11, 1'b0);
    send(16'h694E, 8'h22, 1'b0);
    send_done(16'h694D);
    finish_exec("s1");
    chk("s1_nwr", d_log.size(), 2);
    chk("s1_wr0", d_log[0], {16'h694D, 8'h11});
    chk("s1_wr1", d_log[1], {16'h694E, 8'h22});
    chk("s1_model_wr1", m_log[1], {16'h694E, 8'h22});
    chk("s1_xa", exec_addr, 16'h694D);

    // Six bytes into a stalled depth-4 FIFO.
    do_reset();
    ram_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 3) chk("s2_ready_before_full", in_ready, 1);
      if (i == 4) chk("s2_ready_full", in_ready, 0);
      in_valid = 1'b1;
      in_addr = 16'h1000 + 16'(i);
      in_data = 8'(i + 1);
    end
    send_done(16'h2000);
    ram_ack = 1'b1;
    finish_exec("s2");
    chk("s2_ovf", overflow, 1);
    chk("s2_nwr", d_log.size(), 4);
    chk("s2_wr3", d_log[3], {16'h1003, 8'h04});
    chk("s2_xa", exec_addr, 16'h2000);

    // Done alone from IDLE, plus a stray byte while in EXEC.
    do_reset();
    send_done(16'h0CC1);
    found = 0;
    saw_req = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle_inputs();
      if (ram_req === 1'b1) saw_req = 1;
      if (exec_req === 1'b1) begin
        found = 1;
        break;
      end
    end
    chk("s3_exec_within3", found, 1);
    chk("s3_no_ram_req", saw_req, 0);
    chk("s3_xa", exec_addr, 16'h0CC1);
    in_valid = 1'b1;
    in_addr = 16'h1234;
    in_data = 8'h55;
    @(negedge clk);
    idle_inputs();
    chk("s3_ovf_exec", overflow, 1);
    chk("s3_no_push", ram_req, 0);
    finish_exec("s3");

    // Reset with three entries pending and ram_req high.
    ram_ack = 1'b0;
    send(16'h3000, 8'h01, 1'b0);
    send(16'h3001, 8'h02, 1'b0);
    send(16'h3002, 8'h03, 1'b0);
    @(negedge clk);
    idle_inputs();
    chk("s4_req_pending", ram_req, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("s4_ram_req", ram_req, 0);
    chk("s4_busy", busy, 0);
    chk("s4_hold", cpu_hold, 0);
    chk("s4_exec_req", exec_req, 0);
    chk("s4_ready", in_ready, 1);
    chk("s4_ovf", overflow, 0);
    chk("s4_xa", exec_addr, 16'h0000);
    chk("s4_ck", checksum, 8'h00);
    reset_n = 1'b1;
    ram_ack = 1'b1;
    saw_req = 0;
    repeat (5) begin
      @(negedge clk);
      if (ram_req !== 1'b0) saw_req = 1;
    end
    chk("s4_no_req_after", saw_req, 0);
    chk("s4_nwr", d_log.size(), 0);

    // Byte and done in the same cycle.
    do_reset();
    ram_ack = 1'b1;
    send(16'h8000, 8'hAA, 1'b1);
    @(negedge clk);
    idle_inputs();
    finish_exec("s5");
    chk("s5_nwr", d_log.size(), 1);
    chk("s5_wr0", d_log[0], {16'h8000, 8'hAA});
    chk("s5_xa", exec_addr, 16'h8000);

    // Checksum bytes; exec_ack held during LOAD must be ignored.
    do_reset();
    ram_ack = 1'b1;
    exec_ack = 1'b1;
    send(16'h4000, 8'hF0, 1'b0);
    send(16'h4001, 8'h20, 1'b0);
    send(16'h4002, 8'h05, 1'b0);
    @(negedge clk);
    idle_inputs();
    chk("s6_still_busy", busy, 1);
    exec_ack = 1'b0;
    send_done(16'h4000);
    finish_exec("s6");
    chk("s6_nwr", d_log.size(), 3);
`ifdef TAPE_INJECT_CHECKSUM_EN
    chk("s6_ck", checksum, 8'h15);
`else
    chk("s6_ck", checksum, 8'h00);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tape_inject.md
TAPE_INJECT -- requirements
Module: tape_inject

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered write entries (power of 2, 2..16).
REQ-002 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  in  1  one-cycle strobe, one parsed tape byte present.
REQ-005 SHALL have port in_addr  in  16  target RAM address of byte.
REQ-006 SHALL have port in_data  in  8  tape byte.
REQ-007 SHALL have port in_done  in  1  one-cycle pulse, load finished; in_addr carries exec address.
REQ-008 SHALL have port in_ready  out  1  FIFO not full.
REQ-009 SHALL have ports ram_req out 1, ram_addr out 16, ram_dout out 8, ram_ack in 1 (one-cycle accept of current request).
REQ-010 SHALL have port cpu_hold  out  1  CPU held off bus during injection.
REQ-011 SHALL have ports exec_req out 1, exec_addr out 16, exec_ack in 1 (CPU jump handshake).
REQ-012 SHALL have ports busy out 1 (state != IDLE), overflow out 1 (sticky dropped byte), checksum out 8.

Function
REQ-013 SHALL implement states IDLE, LOAD, DRAIN, EXEC.
REQ-014 IDLE->LOAD on in_valid; IDLE->DRAIN on in_done alone; overflow and checksum clear on leaving IDLE.
REQ-015 LOAD: push {in_addr,in_data} on in_valid when not full; in_done latches exec_addr=in_addr and moves to DRAIN next cycle.
REQ-016 in_valid and in_done same cycle: byte pushed first, then exec_addr latched, state DRAIN.
REQ-017 in_valid while full: byte dropped, overflow set; no push even if pop same cycle; in_ready = not full, registered.
REQ-018 in_valid in DRAIN or EXEC: ignored, overflow set.
REQ-019 ram_req asserted cycle after first push into empty FIFO (latency 1); ram_addr/ram_dout held stable until ram_ack.
REQ-020 On ram_ack: head popped; ram_req stays high next cycle with next entry if FIFO non-empty (back-to-back), else drops.
REQ-021 DRAIN->EXEC in cycle after FIFO empty and no request outstanding; exec_req asserted in EXEC.
REQ-022 EXEC: exec_req held with exec_addr stable until exec_ack; on exec_ack -> IDLE, exec_req and cpu_hold low next cycle.
REQ-023 cpu_hold asserted cycle after leaving IDLE, deasserted only on return to IDLE or reset.
REQ-024 FIFO pointers 1 bit wider than log2(FIFO_DEPTH); wrap modulo 2*FIFO_DEPTH; full/empty from MSB compare.
REQ-025 ram_ack when ram_req low and exec_ack outside EXEC SHALL be ignored.

Reset
REQ-026 reset_n low SHALL clear: state IDLE, FIFO empty, ram_req, exec_req, cpu_hold, busy, overflow 0; exec_addr 0x0000, checksum 0x00, in_ready 1.
REQ-027 Reset mid-transfer SHALL abandon pending entries and outstanding ram_req without waiting for ram_ack.

Configuration
REQ-028 Macro TAPE_INJECT_CHECKSUM_EN defined: checksum = sum mod 256 of ram_dout of every acknowledged write since leaving IDLE, stable after IDLE.
REQ-029 Macro undefined: checksum port present, tied 0x00, no adder logic.

Structure
REQ-030 Shared package tape_pkg SHALL hold state enum, FIFO_DEPTH default, entry type {addr 16, data 8}.
REQ-031 FIFO SHALL be sub-module tape_inject_fifo (push/pop/full/empty/head); FSM and handshakes in tape_inject.

Verification
REQ-032 Writes 0x694D=0x11, 0x694E=0x22, done addr 0x694D, ram_ack every cycle -> two RAM writes in order, exec_req addr 0x694D, IDLE after exec_ack.
REQ-033 Six in_valid back-to-back, ram_ack held low (depth 4) -> in_ready low after 4th, bytes 5-6 dropped, overflow=1, only 4 RAM writes.
REQ-034 in_done alone in IDLE, addr 0x0CC1 -> no ram_req, exec_req within 3 cycles, exec_addr 0x0CC1.
REQ-035 Reset asserted with 3 entries pending and ram_req high -> next cycle all outputs at reset values, no further ram_req.
REQ-036 With TAPE_INJECT_CHECKSUM_EN, bytes 0xF0,0x20,0x05 -> checksum 0x15; without macro -> 0x00.
REQ-037 in_valid and in_done same cycle (addr 0x8000 data 0xAA) -> byte written to 0x8000, then exec_req addr 0x8000.
